// File: rtl/inst_rom_arbiter_if.sv
// inst_rom_arbiter_if
//   Bundles the fetch (F), debug (D), flush and ROM-port signals shared by
//   the instruction-ROM arbiter and its surroundings.
//   Modports:
//     slave  : arbiter view (takes requests and ROM data; drives grants,
//              responses and the ROM chip-enable/address)
//     master : requester/ROM view (the mirror image)
//   Signals:
//     f_req/f_addr/f_gnt/f_rvalid/f_rdata/f_err : fetch requester
//     flush                                     : fetch redirect
//     d_req/d_addr/d_gnt/d_rvalid/d_rdata/d_err : debug requester
//     rom_ce/rom_pc/rom_inst                    : synchronous ROM port
interface inst_rom_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          f_err;
  logic          flush;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          rom_ce;
  logic [AW-1:0] rom_pc;
  logic [DW-1:0] rom_inst;

  modport slave (
    input  f_req, f_addr, flush, d_req, d_addr, rom_inst,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output rom_ce, rom_pc
  );

  modport master (
    output f_req, f_addr, flush, d_req, d_addr, rom_inst,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  rom_ce, rom_pc
  );
endinterface

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter
//   Shares one synchronous instruction-ROM read port between the CPU fetch
//   stage (F) and the debug/loader read-back port (D). Fixed priority F over
//   D, one access per cycle, response exactly one cycle after the grant.
//   Misaligned addresses are granted but never reach the ROM; they return an
//   error response with zero data. flush cancels fetch responses only.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset; all outputs forced to 0
//     bus   : inst_rom_arbiter_if.slave (requests, responses, ROM port)
//   Parameters: AW address width, DW data width, MAX_WAIT starvation limit.
//   Optional feature macro: INST_ROM_ARB_STARVE_GUARD_EN
//     defined   -> D is force-granted after MAX_WAIT cycles of waiting
//     undefined -> strict fixed priority, D may starve
//
//   Owner register (response slot for the next cycle):
//   state    | meaning
//   OWN_NONE | no response due (idle, or fetch cancelled by flush)
//   OWN_F    | fetch response due this cycle
//   OWN_D    | debug response due this cycle
module inst_rom_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_rom_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e        owner_q, owner_nxt;
  logic          err_q, err_nxt;
  logic          force_d;
  logic          f_gnt, d_gnt;
  logic [AW-1:0] gnt_addr;
  logic          f_own, d_own;

`ifdef INST_ROM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!bus.d_req || d_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_d = (wait_cnt == WAIT_MAX) & bus.d_req;
`else
  assign force_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_nxt;
      err_q   <= err_nxt;
    end
  end

  // Grants are gated by rst_n so that a request held through reset cannot
  // reach the ROM or pulse a grant while reset is asserted.
  always_comb begin
    f_gnt     = rst_n & bus.f_req & ~force_d;
    d_gnt     = rst_n & bus.d_req & (~bus.f_req | force_d);
    gnt_addr  = '0;
    owner_nxt = OWN_NONE;
    err_nxt   = 1'b0;
    if (f_gnt) begin
      gnt_addr = bus.f_addr;
      // A fetch granted under flush is consumed but its slot stays empty.
      if (!bus.flush) begin
        owner_nxt = OWN_F;
        err_nxt   = |bus.f_addr[1:0];
      end
    end else if (d_gnt) begin
      gnt_addr  = bus.d_addr;
      owner_nxt = OWN_D;
      err_nxt   = |bus.d_addr[1:0];
    end
  end

  assign bus.f_gnt  = f_gnt;
  assign bus.d_gnt  = d_gnt;
  assign bus.rom_pc = gnt_addr;
  assign bus.rom_ce = (f_gnt | d_gnt) & ~(|gnt_addr[1:0]);

  assign f_own = (owner_q == OWN_F) & ~bus.flush;
  assign d_own = (owner_q == OWN_D);

  assign bus.f_rvalid = f_own;
  assign bus.f_err    = f_own & err_q;
  assign bus.f_rdata  = (f_own & ~err_q) ? bus.rom_inst : '0;

  assign bus.d_rvalid = d_own;
  assign bus.d_err    = d_own & err_q;
  assign bus.d_rdata  = (d_own & ~err_q) ? bus.rom_inst : '0;

endmodule
